// File: rtl/reg_dump_sequencer.sv
// Sweeps the processor's register-observation port, streams each (index, value)
// pair over valid/ready and accumulates a wrapping checksum of the dump.
module reg_dump_sequencer #(
    parameter int RegAddrBits = 3,
    parameter int DataWidth   = 16,
    parameter int TotalReg    = 8,
    parameter int ReadLatency = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    output logic [RegAddrBits-1:0] inr,
    input  logic [DataWidth-1:0]   out_value,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [DataWidth-1:0]   dout,
    output logic [RegAddrBits-1:0] dout_idx,
    output logic                   busy,
    output logic                   done,
    output logic [DataWidth-1:0]   checksum
);

    localparam int CntBits = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
    localparam logic [CntBits-1:0]     CntLoad = CntBits'(ReadLatency - 1);
    localparam logic [RegAddrBits-1:0] LastIdx = RegAddrBits'(TotalReg - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SEND, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CntBits-1:0]     cnt_reg;
    logic [RegAddrBits-1:0] inr_reg;
    logic [RegAddrBits-1:0] dout_idx_reg;
    logic [DataWidth-1:0]   dout_reg;
    logic [DataWidth-1:0]   checksum_reg;
    logic                   dout_valid_reg;

    logic accept, capture, handshake, last_idx;

    assign accept    = (state_reg == IDLE) && start;
    assign capture   = (state_reg == SETTLE) && (cnt_reg == '0);
    assign handshake = (state_reg == SEND) && dout_valid_reg && dout_ready;
    assign last_idx  = (inr_reg == LastIdx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = SETTLE;
            SETTLE:  if (capture)   state_next = SEND;
            SEND:    if (handshake) state_next = last_idx ? DONE : SETTLE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // The wait counter is loaded with ReadLatency-1 on every inr update, so the
    // capture edge lands exactly ReadLatency edges after the select changed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg        <= '0;
            inr_reg        <= '0;
            dout_idx_reg   <= '0;
            dout_reg       <= '0;
            checksum_reg   <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                inr_reg      <= '0;
                cnt_reg      <= CntLoad;
                checksum_reg <= '0;
            end
            if ((state_reg == SETTLE) && !capture) begin
                cnt_reg <= cnt_reg - CntBits'(1);
            end
            if (capture) begin
                dout_reg       <= out_value;
                dout_idx_reg   <= inr_reg;
                dout_valid_reg <= 1'b1;
                checksum_reg   <= checksum_reg + out_value;
            end
            if (handshake) begin
                dout_valid_reg <= 1'b0;
                if (!last_idx) begin
                    inr_reg <= inr_reg + RegAddrBits'(1);
                    cnt_reg <= CntLoad;
                end
            end
        end
    end

    assign inr        = inr_reg;
    assign dout       = dout_reg;
    assign dout_idx   = dout_idx_reg;
    assign dout_valid = dout_valid_reg;
    assign checksum   = checksum_reg;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Drives two sequencers (read latency 1 and 3) against register-file stubs and
// compares the streamed dump with a queue/array reference model.
module tb_reg_dump_sequencer;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int NR = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic sel = 1'b0;

    always #5 CLK = ~CLK;

    logic [AW-1:0] inr1, inr3, idx1, idx3;
    logic [DW-1:0] ov1, ov3, dout1, dout3, cs1, cs3;
    logic          v1, v3, busy1, busy3, done1, done3;
    logic          start1, start3;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] pipe_a, pipe_b;

    // Latency-1 stub answers combinationally; latency-3 stub is two registers deep,
    // so its data is only valid to sample on the third edge after inr moves.
    assign ov1 = regs[inr1];
    always @(posedge CLK) begin
        pipe_a <= regs[inr3];
        pipe_b <= pipe_a;
    end
    assign ov3 = pipe_b;

    assign start1 = start & ~sel;
    assign start3 = start & sel;

    reg_dump_sequencer #(.RegAddrBits(AW), .DataWidth(DW), .TotalReg(NR), .ReadLatency(1)) dut (
        .CLK(CLK), .RST(RST), .start(start1), .inr(inr1), .out_value(ov1),
        .dout_valid(v1), .dout_ready(ready), .dout(dout1), .dout_idx(idx1),
        .busy(busy1), .done(done1), .checksum(cs1));

    reg_dump_sequencer #(.RegAddrBits(AW), .DataWidth(DW), .TotalReg(NR), .ReadLatency(3)) dut3 (
        .CLK(CLK), .RST(RST), .start(start3), .inr(inr3), .out_value(ov3),
        .dout_valid(v3), .dout_ready(ready), .dout(dout3), .dout_idx(idx3),
        .busy(busy3), .done(done3), .checksum(cs3));

    logic [AW-1:0] m_idx, m_inr;
    logic [DW-1:0] m_dout, m_cs;
    logic          m_valid, m_busy, m_done;
    assign m_idx   = sel ? idx3  : idx1;
    assign m_inr   = sel ? inr3  : inr1;
    assign m_dout  = sel ? dout3 : dout1;
    assign m_cs    = sel ? cs3   : cs1;
    assign m_valid = sel ? v3    : v1;
    assign m_busy  = sel ? busy3 : busy1;
    assign m_done  = sel ? done3 : done1;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int            q_idx[$];
    logic [DW-1:0] q_val[$];
    int            q_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            start_cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dout;
    logic [AW-1:0] prev_idx;

    // Observes on the falling edge: records handshakes, done pulses, and
    // checks that a stalled output holds steady.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (m_valid && ready) begin
                q_idx.push_back(int'(m_idx));
                q_val.push_back(m_dout);
                q_cyc.push_back(cyc);
                $display("handshake cyc=%0d idx=%0d value=%h", cyc, m_idx, m_dout);
            end
            if (m_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (start && !m_busy) start_cyc = cyc + 1;
            if (prev_stall) begin
                total = total + 1;
                if (!m_valid || m_dout !== prev_dout || m_idx !== prev_idx)
                    $display("FAIL stall_hold: valid=%0b dout=%h idx=%0d required valid=1 dout=%h idx=%0d",
                             m_valid, m_dout, m_idx, prev_dout, prev_idx);
                else passed = passed + 1;
            end
            prev_stall = m_valid && !ready;
            prev_dout  = m_dout;
            prev_idx   = m_idx;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_rec();
        q_idx.delete();
        q_val.delete();
        q_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (done_cnt == 0) $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        else passed++;
        repeat (3) step();
    endtask

    task automatic check_sweep(input string name, input int exp_cycles);
        int s = 0;
        logic [DW-1:0] exp_cs;
        for (int i = 0; i < NR; i++) s += int'(regs[i]);
        exp_cs = DW'(s);
        total++;
        if (q_idx.size() != NR) $display("FAIL %s_count: got %0d outputs, required %0d", name, q_idx.size(), NR);
        else passed++;
        for (int i = 0; i < q_idx.size() && i < NR; i++) begin
            total++;
            if (q_idx[i] !== i || q_val[i] !== regs[i])
                $display("FAIL %s_item%0d: idx=%0d value=%h required idx=%0d value=%h",
                         name, i, q_idx[i], q_val[i], i, regs[i]);
            else passed++;
        end
        total++;
        if (m_cs !== exp_cs) $display("FAIL %s_checksum: got %h required %h", name, m_cs, exp_cs);
        else passed++;
        total++;
        if (done_cnt != 1) $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt);
        else passed++;
        total++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL %s_idle_after: busy=%0b valid=%0b required 0 0", name, m_busy, m_valid);
        else passed++;
        if (exp_cycles >= 0) begin
            total++;
            if (done_cyc - start_cyc != exp_cycles)
                $display("FAIL %s_latency: got %0d edges required %0d", name, done_cyc - start_cyc, exp_cycles);
            else passed++;
        end
    endtask

    task automatic load_program();
        for (int i = 0; i < NR; i++) regs[i] = '0;
        regs[1] = 16'h0003;
        regs[2] = 16'h0004;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        total++;
        if ({inr1, v1, dout1, idx1, busy1, done1, cs1} !== '0)
            $display("FAIL reset_lat1: inr=%0d valid=%0b dout=%h idx=%0d busy=%0b done=%0b cs=%h required all 0",
                     inr1, v1, dout1, idx1, busy1, done1, cs1);
        else passed++;
        total++;
        if ({inr3, v3, dout3, idx3, busy3, done3, cs3} !== '0)
            $display("FAIL reset_lat3: inr=%0d valid=%0b dout=%h idx=%0d busy=%0b done=%0b cs=%h required all 0",
                     inr3, v3, dout3, idx3, busy3, done3, cs3);
        else passed++;
        step();
        RST = 1'b0;
    endtask

    task automatic test_program();
        sel = 1'b0;
        ready = 1'b1;
        load_program();
        clear_rec();
        pulse_start();
        wait_done("program", 200);
        check_sweep("program", NR * 2);
        total++;
        if (m_cs !== 16'h0007) $display("FAIL program_cs_const: got %h required 0007", m_cs);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        sel = 1'b0;
        ready = 1'b1;
        load_program();
        clear_rec();
        pulse_start();
        while (!(m_valid && m_idx == 1) && n < 50) begin
            step();
            n++;
        end
        ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            total++;
            if (m_valid !== 1'b1 || m_dout !== 16'h0003 || m_idx !== 3'd1 || m_inr !== 3'd1)
                $display("FAIL bp_hold%0d: valid=%0b dout=%h idx=%0d inr=%0d required 1 0003 1 1",
                         j, m_valid, m_dout, m_idx, m_inr);
            else passed++;
        end
        total++;
        if (q_idx.size() != 1) $display("FAIL bp_no_capture: got %0d outputs required 1", q_idx.size());
        else passed++;
        ready = 1'b1;
        wait_done("bp", 200);
        check_sweep("bp", NR * 2 + 5);
    endtask

    task automatic test_latency3();
        sel = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        clear_rec();
        pulse_start();
        wait_done("lat3", 300);
        check_sweep("lat3", NR * 4);
        for (int i = 1; i < q_cyc.size(); i++) begin
            total++;
            if (q_cyc[i] - q_cyc[i-1] != 4)
                $display("FAIL lat3_spacing%0d: got %0d cycles required 4", i, q_cyc[i] - q_cyc[i-1]);
            else passed++;
        end
        sel = 1'b0;
    endtask

    task automatic test_start_ignored();
        bit sent_send = 1'b0;
        bit sent_done = 1'b0;
        int n = 0;
        sel = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        clear_rec();
        pulse_start();
        while (!sent_done && n < 200) begin
            step();
            n++;
            start = 1'b0;
            if (m_done) begin
                start = 1'b1;
                sent_done = 1'b1;
            end else if (m_valid && m_idx == 3 && !sent_send) begin
                start = 1'b1;
                sent_send = 1'b1;
            end
        end
        step();
        start = 1'b0;
        repeat (6) step();
        total++;
        if (!(sent_send && sent_done))
            $display("FAIL ignore_stimulus: send_pulse=%0b done_pulse=%0b required 1 1", sent_send, sent_done);
        else passed++;
        check_sweep("ignore", NR * 2);
    endtask

    task automatic test_async_reset();
        int n = 0;
        sel = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom_range(1, 65535));
        clear_rec();
        pulse_start();
        while (!(m_busy && !m_valid && m_inr == 4) && n < 100) begin
            step();
            n++;
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_inr !== '0 || m_cs !== '0 || m_done !== 1'b0)
            $display("FAIL async_reset: busy=%0b valid=%0b inr=%0d cs=%h done=%0b required all 0",
                     m_busy, m_valid, m_inr, m_cs, m_done);
        else passed++;
        step();
        RST = 1'b0;
        clear_rec();
        pulse_start();
        wait_done("after_rst", 200);
        check_sweep("after_rst", NR * 2);
    endtask

    task automatic test_checksum_wrap();
        sel = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = 16'hF000;
        clear_rec();
        pulse_start();
        wait_done("wrap", 200);
        check_sweep("wrap", NR * 2);
        total++;
        if (m_cs !== 16'h8000) $display("FAIL wrap_const: got %h required 8000", m_cs);
        else passed++;
    endtask

    task automatic test_random_ready(input logic which);
        int n = 0;
        sel = which;
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        ready = 1'b1;
        clear_rec();
        pulse_start();
        while (done_cnt == 0 && n < 1000) begin
            ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        ready = 1'b1;
        wait_done(which ? "rand3" : "rand1", 10);
        check_sweep(which ? "rand3" : "rand1", -1);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_backpressure();
        test_latency3();
        test_start_ignored();
        test_async_reset();
        test_checksum_wrap();
        test_random_ready(1'b0);
        test_random_ready(1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
